// File: rtl/regbank_pkg.sv
// regbank_pkg: shared register-bank geometry and write-arbiter FSM state type
package regbank_pkg;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 32;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin one-hot selection, searching from the requester after ptr
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);
    logic [PW-1:0] idx;
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!valid && eligible[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: round-robin write arbiter for the register bank with a zero-fill sequence
module regbank_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = regbank_pkg::AW,
    parameter int DW   = regbank_pkg::DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_dr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic              clear_start,
    output logic [NREQ-1:0]   gnt,
    output logic              write,
    output logic [AW-1:0]     dr,
    output logic [DW-1:0]     wrData,
    output logic              busy,
    output logic              clear_done
);
    import regbank_pkg::*;
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    state_t          state_q;
    logic [4:0]      cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic            write_q;
    logic [AW-1:0]   dr_q;
    logic [DW-1:0]   wrdata_q;
    logic            busy_q;
    logic            done_q;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [AW-1:0]   pick_dr;
    logic [DW-1:0]   pick_data;
    // a requester still showing gnt is masked so its lingering req is not re-granted
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .eligible (req & ~gnt_q),
        .ptr      (ptr_q),
        .pick     (pick),
        .valid    (pick_vld)
    );
    always_comb begin
        pick_idx  = '0;
        pick_dr   = '0;
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx  = PW'(i);
                pick_dr   = req_dr[i*AW +: AW];
                pick_data = req_data[i*DW +: DW];
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= PW'(NREQ - 1);
            gnt_q    <= '0;
            write_q  <= 1'b0;
            dr_q     <= '0;
            wrdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            gnt_q   <= '0;
            write_q <= 1'b0;
            dr_q    <= '0;
            done_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (clear_start) begin
                    state_q  <= CLEAR;
                    cnt_q    <= '0;
                    write_q  <= 1'b1;
                    wrdata_q <= '0;
                    busy_q   <= 1'b1;
                end else if (pick_vld) begin
                    gnt_q    <= pick;
                    write_q  <= 1'b1;
                    dr_q     <= pick_dr;
                    wrdata_q <= pick_data;
                    ptr_q    <= pick_idx;
                end
            end else begin
                cnt_q <= cnt_q + 5'd1;
                // the counter mirrors the dr already on the bus; the wrap ends the sweep
                if (cnt_q == 5'(NREGS - 1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    write_q <= 1'b1;
                    dr_q    <= AW'(cnt_q + 5'd1);
                end
            end
        end
    end
    assign gnt        = gnt_q;
    assign write      = write_q;
    assign dr         = dr_q;
    assign wrData     = wrdata_q;
    assign busy       = busy_q;
    assign clear_done = done_q;
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb_regbank_wr_arbiter: vector table, clear/reset sequences and random run against a reference model
module tb_regbank_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [14:0] req_dr;
    logic [95:0] req_data;
    logic        clear_start;
    logic [2:0]  gnt;
    logic        write;
    logic [4:0]  dr;
    logic [31:0] wrData;
    logic        busy;
    logic        clear_done;
    logic [42:0] outv;
    logic [31:0] bank [32];
    int checks = 0;
    int errors = 0;
    int m_last, m_clr;
    logic [2:0]  m_g;
    logic        m_w, m_b, m_c;
    logic [4:0]  m_a;
    logic [31:0] m_d;

    regbank_wr_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_dr      (req_dr),
        .req_data    (req_data),
        .clear_start (clear_start),
        .gnt         (gnt),
        .write       (write),
        .dr          (dr),
        .wrData      (wrData),
        .busy        (busy),
        .clear_done  (clear_done)
    );

    always #5 clk = ~clk;
    assign outv = {gnt, write, dr, wrData, busy, clear_done};
    always @(posedge clk) if (write) bank[dr] <= wrData;

    typedef struct {
        logic [2:0]  r;
        logic [14:0] a;
        logic [95:0] d;
        logic        cs;
        logic [42:0] e;
    } vec_t;
    vec_t tv [15];

    function automatic logic [14:0] pa(input int a0, input int a1, input int a2);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction
    function automatic logic [95:0] pd(input int d0, input int d1, input int d2);
        return {32'(d2), 32'(d1), 32'(d0)};
    endfunction
    function automatic logic [42:0] ev(input logic [2:0] g, input logic w, input int a, input int d,
                                       input logic b, input logic c);
        return {g, w, 5'(a), 32'(d), b, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        req = '0;
        req_dr = '0;
        req_data = '0;
        clear_start = 1'b0;
        repeat (2) tick;
        chk("reset_state", 64'(outv), 64'd0);
        reset = 1'b1;
        m_last = 2;
        m_clr = -1;
        m_g = '0; m_w = 0; m_b = 0; m_c = 0; m_a = '0; m_d = '0;
    endtask

    // reference: one accepted write per edge, clear sweeps 32 addresses, grants rotate after last winner
    task automatic model_step(input logic [2:0] r, input logic [14:0] a, input logic [95:0] d, input logic c);
        logic [2:0] pg;
        pg = m_g;
        m_g = '0; m_w = 0; m_a = '0; m_c = 0;
        if (m_clr >= 0) begin
            if (m_clr == 31) begin
                m_clr = -1; m_b = 0; m_c = 1;
            end else begin
                m_clr++; m_w = 1; m_a = 5'(m_clr);
            end
        end else if (c) begin
            m_clr = 0; m_w = 1; m_d = '0; m_b = 1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (m_last + k) % 3;
                if (m_g == 0 && r[i] && !pg[i]) begin
                    m_g = 3'(1 << i); m_w = 1; m_a = a[i*5 +: 5]; m_d = d[i*32 +: 32]; m_last = i;
                end
            end
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, nz;
        bit got;
        tv[0]  = '{3'b111, pa(1,2,3),  pd(100,200,300), 1'b0, ev(3'b001,1,1,100,0,0)};
        tv[1]  = '{3'b111, pa(1,2,3),  pd(100,200,300), 1'b0, ev(3'b010,1,2,200,0,0)};
        tv[2]  = '{3'b111, pa(1,2,3),  pd(100,200,300), 1'b0, ev(3'b100,1,3,300,0,0)};
        tv[3]  = '{3'b000, pa(0,0,0),  pd(0,0,0),       1'b0, ev(3'b000,0,0,300,0,0)};
        tv[4]  = '{3'b010, pa(0,5,0),  pd(0,55,0),      1'b0, ev(3'b010,1,5,55,0,0)};
        tv[5]  = '{3'b000, pa(0,0,0),  pd(0,0,0),       1'b0, ev(3'b000,0,0,55,0,0)};
        tv[6]  = '{3'b011, pa(6,7,0),  pd(66,77,0),     1'b0, ev(3'b001,1,6,66,0,0)};
        tv[7]  = '{3'b010, pa(6,7,0),  pd(66,77,0),     1'b0, ev(3'b010,1,7,77,0,0)};
        tv[8]  = '{3'b000, pa(0,0,0),  pd(0,0,0),       1'b0, ev(3'b000,0,0,77,0,0)};
        tv[9]  = '{3'b101, pa(9,0,9),  pd(1,0,2),       1'b0, ev(3'b100,1,9,2,0,0)};
        tv[10] = '{3'b001, pa(9,0,9),  pd(1,0,2),       1'b0, ev(3'b001,1,9,1,0,0)};
        tv[11] = '{3'b001, pa(9,0,9),  pd(1,0,2),       1'b0, ev(3'b000,0,0,1,0,0)};
        tv[12] = '{3'b001, pa(9,0,9),  pd(1,0,2),       1'b0, ev(3'b001,1,9,1,0,0)};
        tv[13] = '{3'b100, pa(9,0,12), pd(1,0,44),      1'b1, ev(3'b000,1,0,0,1,0)};
        tv[14] = '{3'b100, pa(9,0,12), pd(1,0,44),      1'b0, ev(3'b000,1,1,0,1,0)};
        do_reset;
        for (int v = 0; v < 15; v++) begin
            req = tv[v].r; req_dr = tv[v].a; req_data = tv[v].d; clear_start = tv[v].cs;
            tick;
            chk($sformatf("vec%0d", v), 64'(outv), 64'(tv[v].e));
        end
        // clear sweep with req[2] pending and a stray clear_start that must be ignored
        for (int i = 2; i < 32; i++) begin
            clear_start = (i == 5);
            tick;
            chk("clr_sweep", 64'(outv), 64'(ev(3'b000,1,i,0,1,0)));
        end
        clear_start = 1'b0;
        tick;
        chk("clr_done", 64'(outv), 64'(ev(3'b000,0,0,0,0,1)));
        tick;
        chk("clr_then_gnt2", 64'(outv), 64'(ev(3'b100,1,12,44,0,0)));
        req = '0;
        tick;
        chk("idle_hold", 64'(outv), 64'(ev(3'b000,0,0,44,0,0)));

        // fill every register through requester 0, then zero-fill
        for (int k = 0; k < 32; k++) begin
            req = 3'b001; req_dr = pa(k,0,0); req_data = pd(10*k,0,0);
            got = 0;
            for (int t = 0; t < 4 && !got; t++) begin
                tick;
                got = gnt[0];
            end
            if (!got) chk("fill_gnt_timeout", 64'd0, 64'd1);
        end
        req = '0;
        repeat (2) tick;
        chk("reg3_is_30", 64'(bank[3]), 64'd30);
        for (int k = 0; k < 32; k++) chk("fill_reg", 64'(bank[k]), 64'(10*k));
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            busy_cnt += busy;
            done_cnt += clear_done;
            tick;
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        nz = 0;
        for (int k = 0; k < 32; k++) nz += (bank[k] != 0);
        chk("regs_zeroed", 64'(nz), 64'd0);

        // reset in the middle of a clear
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        repeat (10) tick;
        chk("clr_dr10", 64'(dr), 64'd10);
        req = 3'b011; req_dr = pa(4,8,0); req_data = pd(40,80,0);
        #2 reset = 1'b0;
        #1 chk("rst_async_zero", 64'(outv), 64'd0);
        tick;
        chk("rst_held_zero", 64'(outv), 64'd0);
        reset = 1'b1;
        tick;
        chk("post_rst_gnt0", 64'(outv), 64'(ev(3'b001,1,4,40,0,0)));
        tick;
        chk("post_rst_gnt1", 64'(outv), 64'(ev(3'b010,1,8,80,0,0)));

        // randomized traffic against the reference model
        do_reset;
        for (int n = 0; n < 3000; n++) begin
            req = 3'($urandom_range(0, 7));
            req_dr = 15'($urandom);
            req_data = {$urandom, $urandom, $urandom};
            clear_start = ($urandom_range(0, 59) == 0);
            model_step(req, req_dr, req_data, clear_start);
            tick;
            chk("random", 64'(outv), 64'({m_g, m_w, m_a, m_d, m_b, m_c}));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regbank_wr_arbiter.md
REGBANK_WR_ARBITER -- requirements
Module: regbank_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of write requesters.
REQ-002 Parameter AW, default 5: register address width, 32 registers.
REQ-003 Parameter DW, default 32: register data width.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port req, input, NREQ: per-requester write request, level, held until granted.
REQ-007 Port req_dr, input, NREQ*AW: packed destination register per requester, slice i = requester i.
REQ-008 Port req_data, input, NREQ*DW: packed write data per requester, slice i = requester i.
REQ-009 Port clear_start, input, 1: single-cycle pulse requesting a zero-fill of all registers.
REQ-010 Port gnt, output, NREQ: one-hot grant, registered, high for exactly one cycle per accepted request.
REQ-011 Port write, output, 1: register bank write enable, registered.
REQ-012 Port dr, output, AW: register bank write address, registered.
REQ-013 Port wrData, output, DW: register bank write data, registered.
REQ-014 Port busy, output, 1: high while the clear sequence runs.
REQ-015 Port clear_done, output, 1: single-cycle pulse after the last clear write.

Function
REQ-016 The FSM SHALL have two states, IDLE and CLEAR.
REQ-017 In IDLE, each edge SHALL select at most one eligible requester, round-robin, starting from the requester after the last granted one.
REQ-018 Requester i is eligible when req[i]=1 and gnt[i]=0 in the current cycle; this masks re-grant while the requester drops req.
REQ-019 On selection of requester i, the next cycle SHALL show gnt[i]=1, write=1, dr=req_dr slice i and wrData=req_data slice i; the last-granted pointer SHALL update to i.
REQ-020 Latency from a sampled req to gnt/write SHALL be one cycle; the register bank captures at the following edge.
REQ-021 A requester observing gnt[i]=1 SHALL consider its request consumed; it MAY present a new request from the next cycle.
REQ-022 With no eligible requester, write, gnt and dr SHALL be 0; wrData SHALL hold its value.
REQ-023 A clear_start sampled in IDLE SHALL move the FSM to CLEAR, grant nothing that edge, and zero a 5-bit clear counter; clear_start wins over any simultaneous req.
REQ-024 In CLEAR, each cycle SHALL drive write=1, dr=counter and wrData=0, with busy=1 and gnt=0, and SHALL increment the counter.
REQ-025 After the write with dr=31, the FSM SHALL return to IDLE and clear_done SHALL be 1 for exactly that return cycle; the counter wrap SHALL end the sequence (32 writes total).
REQ-026 A clear_start sampled in CLEAR SHALL be ignored.
REQ-027 Pending req during CLEAR SHALL stay pending and be arbitrated from the first IDLE edge; the round-robin pointer is unchanged by CLEAR.
REQ-028 A grant already registered when clear_start is sampled SHALL complete normally; CLEAR writes begin the following cycle.
REQ-029 Requests to the same dr from different requesters SHALL be serialized in grant order, with no merging.

Reset
REQ-030 While reset=0: state IDLE, counter 0, pointer NREQ-1 (requester 0 first), and gnt, write, dr, wrData, busy and clear_done all 0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence without a clear_done pulse; register contents are not guaranteed.
REQ-032 The first arbitration SHALL occur on the first edge after reset deasserts.

Structure
REQ-033 Package regbank_pkg SHALL hold AW, DW, NREGS=32 and the FSM state type; the register bank and this block share it.
REQ-034 The selection logic SHALL be one combinational sub-module, rr_pick (inputs eligible mask and pointer; outputs one-hot pick and valid); everything else is in regbank_wr_arbiter.
REQ-035 Implementation target: 120-400 lines of RTL, no memories, all outputs from flops.

Verification
REQ-036 Single requester: req[0]=1, dr=3, data=30 for one cycle -> gnt[0]=1, write=1, dr=3, wrData=30 one cycle later; reading reg 3 returns 30.
REQ-037 All three requesters held high with dr 1, 2, 3 -> grants in order 0,1,2, one per cycle, with no repeat grant while a gnt is high.
REQ-038 Fairness: after requester 1 is last granted, req=3'b011 -> requester 0 wins next.
REQ-039 Fill all 32 registers with 10*k, then pulse clear_start -> busy high for 32 cycles, dr sweeps 0..31 with wrData=0, clear_done once; all reads return 0.
REQ-040 clear_start coincident with req[2]=1 -> CLEAR first; req[2] is granted on the first IDLE cycle after clear_done.
REQ-041 Reset pulled low at clear counter 10 -> all outputs 0 immediately and no clear_done; after release, req[0] is granted first.
